// File: rtl/task_scheduler_if.sv
// Handshake bundle between submitters, the task scheduler and the chunk engine.
// The master modport is the scheduler's view; slave is the environment's view.
interface task_scheduler_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ID_W   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SIZE_W = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned CNT_W  = 4
) ();
  logic [NUM_CH-1:0]        sub_valid;
  logic [NUM_CH-1:0]        sub_ready;
  logic [NUM_CH*ID_W-1:0]   sub_id;
  logic [NUM_CH*ADDR_W-1:0] sub_addr;
  logic [NUM_CH*SIZE_W-1:0] sub_size;
  logic                     chk_valid;
  logic                     chk_ready;
  logic [ADDR_W-1:0]        chk_addr;
  logic [SIZE_W-1:0]        chk_len;
  logic                     chk_last;
  logic [CH_W-1:0]          chk_ch;
  logic [ID_W-1:0]          active_id;
  logic                     task_active;
  logic                     done_valid;
  logic [ID_W-1:0]          done_id;
  logic [CH_W-1:0]          done_ch;
  logic [NUM_CH*CNT_W-1:0]  q_count;

  modport master (
    input  sub_valid, sub_id, sub_addr, sub_size, chk_ready,
    output sub_ready, chk_valid, chk_addr, chk_len, chk_last, chk_ch,
    output active_id, task_active, done_valid, done_id, done_ch, q_count
  );

  modport slave (
    output sub_valid, sub_id, sub_addr, sub_size, chk_ready,
    input  sub_ready, chk_valid, chk_addr, chk_len, chk_last, chk_ch,
    input  active_id, task_active, done_valid, done_id, done_ch, q_count
  );
endinterface

// File: rtl/task_scheduler.sv
// Multi-channel task scheduler: per-channel FIFOs, round-robin grant, and
// splitting of each granted task into chunk requests of at most CHUNK bytes.
module task_scheduler #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ID_W   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SIZE_W = 32,
  parameter int unsigned CHUNK  = 64,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst_n,
  task_scheduler_if.master bus
);
  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam logic [SIZE_W-1:0] CHUNK_SZ  = SIZE_W'(CHUNK);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  logic [ID_W-1:0]   mem_id   [NUM_CH][DEPTH];
  logic [ADDR_W-1:0] mem_addr [NUM_CH][DEPTH];
  logic [SIZE_W-1:0] mem_size [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];

  state_e            state_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [SIZE_W-1:0] remaining_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   active_id_q;

  logic [NUM_CH-1:0]       ready;
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH*CNT_W-1:0] q_count_flat;
  logic [CH_W-1:0]         rr_idx [NUM_CH];
  logic                    grant_vld;
  logic [CH_W-1:0]         grant;
  logic [SIZE_W-1:0]       len;
  logic                    last;
  logic                    issue;

  // Candidate channel order for this cycle: rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx[i] = CH_W'((32'(rr_ptr_q) + 32'(i)) % NUM_CH);
    end
  end

  // First non-empty channel in round-robin order; lowest i wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (count_q[rr_idx[i]] != '0) begin
        grant_vld = 1'b1;
        grant     = rr_idx[i];
      end
    end
  end

  // Per-channel handshake; ready depends only on the registered count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ready[c] = (count_q[c] < DEPTH_CNT);
      push[c]  = bus.sub_valid[c] && ready[c];
      pop[c]   = (state_q == StIdle) && grant_vld && (grant == CH_W'(c));
      q_count_flat[c*CNT_W +: CNT_W] = count_q[c];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        if (push[c] && !pop[c])      count_q[c] <= count_q[c] + 1'b1;
        else if (pop[c] && !push[c]) count_q[c] <= count_q[c] - 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_id[c][wr_ptr_q[c]]   <= bus.sub_id[c*ID_W +: ID_W];
        mem_addr[c][wr_ptr_q[c]] <= bus.sub_addr[c*ADDR_W +: ADDR_W];
        mem_size[c][wr_ptr_q[c]] <= bus.sub_size[c*SIZE_W +: SIZE_W];
      end
    end
  end

  assign len   = (remaining_q > CHUNK_SZ) ? CHUNK_SZ : remaining_q;
  assign last  = (remaining_q <= CHUNK_SZ);
  assign issue = (state_q == StIssue);

  // Scheduler FSM: grant and load in idle, stream chunks, then report completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_id_q    <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      cur_ch_q    <= '0;
      rr_ptr_q    <= '0;
      active_id_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            cur_id_q    <= mem_id[grant][rd_ptr_q[grant]];
            cur_addr_q  <= mem_addr[grant][rd_ptr_q[grant]];
            remaining_q <= mem_size[grant][rd_ptr_q[grant]];
            cur_ch_q    <= grant;
            active_id_q <= mem_id[grant][rd_ptr_q[grant]];
            rr_ptr_q    <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            state_q     <= (mem_size[grant][rd_ptr_q[grant]] != '0) ? StIssue : StDone;
          end
        end
        StIssue: begin
          if (bus.chk_ready) begin
            // Advancing the base address doubles as the running offset.
            cur_addr_q  <= cur_addr_q + ADDR_W'(len);
            remaining_q <= remaining_q - len;
            if (last) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sub_ready   = ready;
  assign bus.q_count     = q_count_flat;
  assign bus.chk_valid   = issue;
  assign bus.chk_addr    = cur_addr_q;
  assign bus.chk_len     = issue ? len : '0;
  assign bus.chk_last    = issue && last;
  assign bus.chk_ch      = cur_ch_q;
  assign bus.active_id   = active_id_q;
  assign bus.task_active = (state_q != StIdle);
  assign bus.done_valid  = (state_q == StDone);
  assign bus.done_id     = cur_id_q;
  assign bus.done_ch     = cur_ch_q;
endmodule

// File: tb/tb_task_scheduler.sv
// Bench for task_scheduler: directed scenarios plus random traffic, all checked
// against a queue-based transaction model of the scheduler.
module tb_task_scheduler;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ID_W   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 32;
  localparam int unsigned CHUNK  = 64;
  localparam int unsigned CH_W   = 1;
  localparam int unsigned CNT_W  = 3;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] size;
  } job_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
    logic        last;
  } chunk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  task_scheduler_if #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CH_W(CH_W), .CNT_W(CNT_W)
  ) bus ();

  task_scheduler #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
    .CHUNK(CHUNK), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one queue of pending jobs per channel, plus the job in hand.
  job_t        mq [NUM_CH][$];
  int          m_phase;  // 0 waiting for a grant, 1 sending chunks, 2 reporting done
  job_t        m_cur;
  int          m_ch;
  logic [31:0] m_sent;
  int          m_rr;
  logic [31:0] m_act;

  chunk_t      obs_chk [$];
  logic [32:0] obs_done [$];
  int          obs_cyc [$];
  logic [NUM_CH*CNT_W-1:0] snap_qcount;
  logic [NUM_CH-1:0]       snap_ready;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_phase = 0;
    m_cur   = '0;
    m_ch    = 0;
    m_sent  = '0;
    m_rr    = 0;
    m_act   = '0;
  endtask

  task automatic clear_obs();
    obs_chk.delete();
    obs_done.delete();
    obs_cyc.delete();
  endtask

  task automatic compare_outputs();
    logic [31:0] rem;
    logic [31:0] elen;
    rem  = m_cur.size - m_sent;
    elen = (rem > CHUNK) ? 32'(CHUNK) : rem;
    for (int c = 0; c < NUM_CH; c++) begin
      check_eq($sformatf("sub_ready%0d", c), 64'(bus.sub_ready[c]), 64'(mq[c].size() < DEPTH));
      check_eq($sformatf("q_count%0d", c), 64'(bus.q_count[c*CNT_W +: CNT_W]), 64'(mq[c].size()));
    end
    check_eq("chk_valid", 64'(bus.chk_valid), 64'(m_phase == 1));
    if (m_phase == 1) begin
      check_eq("chk_addr", 64'(bus.chk_addr), 64'(32'(m_cur.addr + m_sent)));
      check_eq("chk_len", 64'(bus.chk_len), 64'(elen));
      check_eq("chk_last", 64'(bus.chk_last), 64'(rem <= CHUNK));
      check_eq("chk_ch", 64'(bus.chk_ch), 64'(m_ch));
    end
    check_eq("done_valid", 64'(bus.done_valid), 64'(m_phase == 2));
    if (m_phase == 2) begin
      check_eq("done_id", 64'(bus.done_id), 64'(m_cur.id));
      check_eq("done_ch", 64'(bus.done_ch), 64'(m_ch));
    end
    check_eq("task_active", 64'(bus.task_active), 64'(m_phase != 0));
    check_eq("active_id", 64'(bus.active_id), 64'(m_act));
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic [1:0] sv, input job_t t0, input job_t t1, input logic rdy);
    logic [1:0]  acc;
    int          g;
    logic [31:0] rem;
    @(negedge clk);
    bus.sub_valid = sv;
    bus.sub_id    = {t1.id, t0.id};
    bus.sub_addr  = {t1.addr, t0.addr};
    bus.sub_size  = {t1.size, t0.size};
    bus.chk_ready = rdy;
    #1;
    compare_outputs();
    if (bus.chk_valid && rdy) obs_chk.push_back({bus.chk_addr, bus.chk_len, bus.chk_last});
    if (bus.done_valid) begin
      obs_done.push_back({bus.done_ch, bus.done_id});
      obs_cyc.push_back(cyc);
    end
    snap_qcount = bus.q_count;
    snap_ready  = bus.sub_ready;
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) acc[c] = sv[c] && (mq[c].size() < DEPTH);
    case (m_phase)
      0: begin
        g = -1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (g < 0 && mq[(m_rr + i) % NUM_CH].size() > 0) g = (m_rr + i) % NUM_CH;
        end
        if (g >= 0) begin
          m_cur   = mq[g].pop_front();
          m_ch    = g;
          m_sent  = '0;
          m_rr    = (g + 1) % NUM_CH;
          m_act   = m_cur.id;
          m_phase = (m_cur.size != 0) ? 1 : 2;
        end
      end
      1: begin
        if (rdy) begin
          rem = m_cur.size - m_sent;
          m_sent = m_sent + ((rem > CHUNK) ? 32'(CHUNK) : rem);
          if (rem <= CHUNK) m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
    if (acc[0]) mq[0].push_back(t0);
    if (acc[1]) mq[1].push_back(t1);
    cyc++;
  endtask

  task automatic check_chunks(input string tag, input int n, input logic [31:0] a [4],
                              input logic [31:0] l [4], input logic lst [4]);
    check_eq({tag, "_count"}, 64'(obs_chk.size()), 64'(n));
    for (int i = 0; i < n && i < obs_chk.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 64'(obs_chk[i].addr), 64'(a[i]));
      check_eq($sformatf("%s_len%0d", tag, i), 64'(obs_chk[i].len), 64'(l[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 64'(obs_chk[i].last), 64'(lst[i]));
    end
  endtask

  initial begin
    job_t        none;
    job_t        ja;
    job_t        jb;
    int          base;
    logic [31:0] ea [4];
    logic [31:0] el [4];
    logic        elst [4];
    logic [32:0] order [6];
    logic [1:0]  sv;

    none = '0;
    bus.sub_valid = '0;
    bus.sub_id    = '0;
    bus.sub_addr  = '0;
    bus.sub_size  = '0;
    bus.chk_ready = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_sub_ready", 64'(bus.sub_ready), 64'(2'b11));
    check_eq("rst_q_count", 64'(bus.q_count), 64'(0));
    check_eq("rst_chk_valid", 64'(bus.chk_valid), 64'(0));
    check_eq("rst_chk_len", 64'(bus.chk_len), 64'(0));
    check_eq("rst_chk_last", 64'(bus.chk_last), 64'(0));
    check_eq("rst_done_valid", 64'(bus.done_valid), 64'(0));
    check_eq("rst_task_active", 64'(bus.task_active), 64'(0));
    check_eq("rst_active_id", 64'(bus.active_id), 64'(0));
    rst_n = 1'b1;

    // 200-byte task on ch0 with the engine always ready.
    clear_obs();
    step(2'b01, '{id: 32'h11, addr: 32'h1000, size: 32'd200}, none, 1'b1);
    repeat (9) step(2'b00, none, none, 1'b1);
    ea = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
    el = '{32'd64, 32'd64, 32'd64, 32'd8};
    elst = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_chunks("t200", 4, ea, el, elst);
    check_eq("t200_done_count", 64'(obs_done.size()), 64'(1));
    if (obs_done.size() > 0) check_eq("t200_done", 64'(obs_done[0]), 64'({1'b0, 32'h11}));

    // Zero-size task on ch1: completion without any chunk.
    clear_obs();
    base = cyc;
    step(2'b10, none, '{id: 32'h22, addr: 32'h0, size: 32'd0}, 1'b1);
    repeat (4) step(2'b00, none, none, 1'b1);
    check_eq("zero_chunks", 64'(obs_chk.size()), 64'(0));
    check_eq("zero_done_count", 64'(obs_done.size()), 64'(1));
    if (obs_done.size() > 0) begin
      check_eq("zero_done", 64'(obs_done[0]), 64'({1'b1, 32'h22}));
      check_eq("zero_done_cycle", 64'(obs_cyc[0]), 64'(base + 2));
    end

    // Fill ch1 while the engine stalls: one job in hand, four queued.
    for (int i = 0; i < 5; i++) begin
      step(2'b10, none, '{id: 32'h30 + i, addr: 32'h3000, size: 32'd100}, 1'b0);
    end
    step(2'b10, none, '{id: 32'h3F, addr: 32'h3000, size: 32'd100}, 1'b0);
    check_eq("full_q_count1", 64'(snap_qcount[CNT_W +: CNT_W]), 64'(4));
    check_eq("full_sub_ready1", 64'(snap_ready[1]), 64'(0));
    // Release the engine while still offering pushes, then stall mid-task.
    for (int i = 0; i < 8; i++) begin
      step(2'b10, none, '{id: 32'h40 + i, addr: 32'h4000, size: 32'd100}, 1'b1);
    end
    repeat (3) step(2'b00, none, none, 1'b0);

    // Asynchronous reset in the middle of a stalled task.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_chk_valid", 64'(bus.chk_valid), 64'(0));
    check_eq("arst_task_active", 64'(bus.task_active), 64'(0));
    check_eq("arst_q_count", 64'(bus.q_count), 64'(0));
    check_eq("arst_sub_ready", 64'(bus.sub_ready), 64'(2'b11));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (6) step(2'b00, none, none, 1'b1);
    check_eq("arst_no_done", 64'(obs_done.size()), 64'(0));

    // Preload both channels, then release: completions alternate channels.
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      ja = '{id: 32'hA0 + i, addr: 32'h5000, size: 32'd64};
      jb = '{id: 32'hB0 + i, addr: 32'h6000, size: 32'd64};
      step(2'b11, ja, jb, 1'b0);
    end
    repeat (24) step(2'b00, none, none, 1'b1);
    order = '{{1'b0, 32'hA0}, {1'b1, 32'hB0}, {1'b0, 32'hA1},
              {1'b1, 32'hB1}, {1'b0, 32'hA2}, {1'b1, 32'hB2}};
    check_eq("rr_done_count", 64'(obs_done.size()), 64'(6));
    for (int i = 0; i < 6 && i < obs_done.size(); i++) begin
      check_eq($sformatf("rr_done%0d", i), 64'(obs_done[i]), 64'(order[i]));
    end

    // 130-byte task with the engine ready only every other cycle.
    clear_obs();
    step(2'b01, '{id: 32'h55, addr: 32'h2000, size: 32'd130}, none, 1'b1);
    for (int i = 0; i < 16; i++) step(2'b00, none, none, logic'(i % 2));
    ea = '{32'h2000, 32'h2040, 32'h2080, 32'h0};
    el = '{32'd64, 32'd64, 32'd2, 32'd0};
    elst = '{1'b0, 1'b0, 1'b1, 1'b0};
    check_chunks("t130", 3, ea, el, elst);

    // Random traffic, including address wrap and odd sizes.
    for (int n = 0; n < 800; n++) begin
      sv[0] = ($urandom_range(0, 3) == 0);
      sv[1] = ($urandom_range(0, 3) == 0);
      ja.id   = $urandom;
      ja.addr = $urandom;
      ja.size = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      jb.id   = $urandom;
      jb.addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF80 : $urandom;
      jb.size = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      step(sv, ja, jb, logic'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
